// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with oversampled 2-of-3 majority bit decisions
module uart_rx #(
    parameter int OS_RATE = 16
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       rx_en,
    input  logic       rx_serial_data,
    output logic [7:0] rx_data_out,
    output logic       rx_data_valid,
    output logic       rx_frame_err,
    output logic       rx_busy
);

    localparam int CW = $clog2(OS_RATE);

    // Tick counts at which the line is sampled; the decision is made at the last one
    localparam logic [CW-1:0] CNT_S0   = CW'(OS_RATE / 2 - 2);
    localparam logic [CW-1:0] CNT_S1   = CW'(OS_RATE / 2 - 1);
    localparam logic [CW-1:0] CNT_DEC  = CW'(OS_RATE / 2);
    localparam logic [CW-1:0] CNT_LAST = CW'(OS_RATE - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t        state_q;
    logic          sync1_q;
    logic          rxs_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    idx_q;
    logic [7:0]    shift_q;
    logic          samp0_q;
    logic          samp1_q;
    logic [7:0]    data_q;
    logic          valid_q;
    logic          err_q;

    logic          at_dec;
    logic          at_end;
    logic          bit_d;
    logic [CW-1:0] cnt_d;

    // Two-flop synchronizer; idles high so reset never looks like a start bit
    always_ff @(posedge clk_in) begin
        if (rst) begin
            sync1_q <= 1'b1;
            rxs_q   <= 1'b1;
        end else begin
            sync1_q <= rx_serial_data;
            rxs_q   <= sync1_q;
        end
    end

    // Decision-tick helpers and the 2-of-3 vote (third sample is the live value)
    always_comb begin
        at_dec = rx_en && (cnt_q == CNT_DEC);
        at_end = rx_en && (cnt_q == CNT_LAST);
        bit_d  = (samp0_q & samp1_q) | (samp0_q & rxs_q) | (samp1_q & rxs_q);
        cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
    end

    // Receive state machine with registered data and pulse outputs
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            samp0_q <= 1'b0;
            samp1_q <= 1'b0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;

            if (rx_en && (state_q == ST_START || state_q == ST_DATA || state_q == ST_STOP)) begin
                cnt_q <= cnt_d;
                if (cnt_q == CNT_S0) begin
                    samp0_q <= rxs_q;
                end
                if (cnt_q == CNT_S1) begin
                    samp1_q <= rxs_q;
                end
            end

            case (state_q)
                ST_IDLE: begin
                    // Leaving idle is not tied to a tick so the start edge is caught promptly
                    if (!rxs_q) begin
                        state_q <= ST_START;
                        cnt_q   <= '0;
                    end
                end
                ST_START: begin
                    if (at_dec && bit_d) begin
                        state_q <= ST_IDLE;
                    end else if (at_end) begin
                        state_q <= ST_DATA;
                        idx_q   <= '0;
                    end
                end
                ST_DATA: begin
                    if (at_dec) begin
                        shift_q[idx_q] <= bit_d;
                    end
                    if (at_end) begin
                        if (idx_q == 3'd7) begin
                            state_q <= ST_STOP;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end
                end
                ST_STOP: begin
                    // Finishing at mid-stop lets a back-to-back start bit be seen on time
                    if (at_dec) begin
                        if (bit_d) begin
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= ST_BREAK;
                        end
                    end
                end
                ST_BREAK: begin
                    if (rx_en && rxs_q) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign rx_data_out   = data_q;
    assign rx_data_valid = valid_q;
    assign rx_frame_err  = err_q;
    assign rx_busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed and randomized frames checked against a frame-level model
module tb_uart_rx;

    localparam int OS  = 16;
    localparam int CPT = 4;

    logic       clk_in = 1'b0;
    logic       rst = 1'b1;
    logic       rx_en = 1'b0;
    logic       rx_serial_data = 1'b1;
    logic [7:0] rx_data_out;
    logic       rx_data_valid;
    logic       rx_frame_err;
    logic       rx_busy;

    int checks = 0;
    int failures = 0;

    int         n_valid = 0;
    int         n_err = 0;
    int         busy_cycles = 0;
    logic [7:0] mon_data = 8'h00;
    logic       both_high = 1'b0;

    int         exp_valid = 0;
    int         exp_err = 0;
    logic [7:0] exp_data = 8'h00;

    always #5 clk_in = ~clk_in;

    uart_rx #(.OS_RATE(OS)) dut (
        .clk_in         (clk_in),
        .rst            (rst),
        .rx_en          (rx_en),
        .rx_serial_data (rx_serial_data),
        .rx_data_out    (rx_data_out),
        .rx_data_valid  (rx_data_valid),
        .rx_frame_err   (rx_frame_err),
        .rx_busy        (rx_busy)
    );

    always @(negedge clk_in) begin
        if (rx_data_valid) begin
            n_valid++;
            mon_data = rx_data_out;
        end
        if (rx_frame_err) n_err++;
        if (rx_data_valid && rx_frame_err) both_high = 1'b1;
        if (rx_busy) busy_cycles++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One oversample tick: rx_en high in the first of CPT cycles, line held for all
    task automatic tick(input logic v);
        for (int c = 0; c < CPT; c++) begin
            @(negedge clk_in);
            rx_en = (c == 0);
            rx_serial_data = v;
        end
    endtask

    // One bit period; inv in 6..8 flips that mid-bit sample, -1 for a clean bit
    task automatic send_bit(input logic v, input int inv);
        for (int k = 0; k < OS; k++) tick((k == inv) ? ~v : v);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input bit noisy);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++)
            send_bit(bits[i], noisy ? int'($urandom_range(6, 8)) : -1);
    endtask

    task automatic model_frame(input logic [7:0] b, input logic stop);
        if (stop) begin
            exp_valid++;
            exp_data = b;
        end else begin
            exp_err++;
        end
    endtask

    task automatic check_state(input string tag);
        #1;
        chk({tag, "_valid_cnt"}, n_valid, exp_valid);
        chk({tag, "_err_cnt"}, n_err, exp_err);
        chk({tag, "_data"}, rx_data_out, exp_data);
    endtask

    initial begin
        logic [7:0] b;
        logic       stop;
        bit         noisy;

        // Reset state
        repeat (3) @(negedge clk_in);
        #1;
        chk("rst_data", rx_data_out, 8'h00);
        chk("rst_valid", rx_data_valid, 1'b0);
        chk("rst_err", rx_frame_err, 1'b0);
        chk("rst_busy", rx_busy, 1'b0);
        @(negedge clk_in);
        rst = 1'b0;
        send_bit(1'b1, -1);

        // Clean 0xA5
        send_frame(8'hA5, 1'b1, 1'b0);
        model_frame(8'hA5, 1'b1);
        check_state("a5");
        chk("a5_mon_data", mon_data, 8'hA5);
        chk("a5_busy_after", rx_busy, 1'b0);
        send_bit(1'b1, -1);

        // Short low glitch must be rejected
        busy_cycles = 0;
        for (int k = 0; k < 4; k++) tick(1'b0);
        for (int k = 0; k < 20; k++) tick(1'b1);
        check_state("glitch");
        chk("glitch_went_busy", busy_cycles > 0, 1'b1);
        chk("glitch_busy_short", busy_cycles < 9 * CPT, 1'b1);
        chk("glitch_idle", rx_busy, 1'b0);

        // Framing error, held-low break, then recovery
        send_frame(8'h3C, 1'b0, 1'b0);
        model_frame(8'h3C, 1'b0);
        for (int k = 0; k < 40; k++) tick(1'b0);
        #1;
        chk("break_busy", rx_busy, 1'b1);
        send_bit(1'b1, -1);
        check_state("break");
        chk("break_keeps_a5", rx_data_out, 8'hA5);
        send_frame(8'h11, 1'b1, 1'b0);
        model_frame(8'h11, 1'b1);
        check_state("after_break");

        // Back-to-back frames with no idle gap
        send_frame(8'h00, 1'b1, 1'b0);
        model_frame(8'h00, 1'b1);
        check_state("b2b_first");
        send_frame(8'hFF, 1'b1, 1'b0);
        model_frame(8'hFF, 1'b1);
        check_state("b2b_second");
        send_bit(1'b1, -1);

        // Reset during data bit 4 of 0x77 aborts it
        send_bit(1'b0, -1);
        for (int i = 0; i < 4; i++) send_bit(((8'h77 >> i) & 8'h01) != 0, -1);
        for (int k = 0; k < 8; k++) tick(1'b1);
        @(negedge clk_in);
        rx_en = 1'b0;
        rst = 1'b1;
        @(negedge clk_in);
        #1;
        chk("midrst_data", rx_data_out, 8'h00);
        chk("midrst_valid", rx_data_valid, 1'b0);
        chk("midrst_err", rx_frame_err, 1'b0);
        chk("midrst_busy", rx_busy, 1'b0);
        @(negedge clk_in);
        rst = 1'b0;
        exp_data = 8'h00;
        send_bit(1'b1, -1);
        send_bit(1'b1, -1);
        check_state("midrst_abort");
        send_frame(8'h5A, 1'b1, 1'b0);
        model_frame(8'h5A, 1'b1);
        check_state("after_rst");
        send_bit(1'b1, -1);

        // One flipped mid-bit sample in every bit
        send_frame(8'h81, 1'b1, 1'b1);
        model_frame(8'h81, 1'b1);
        check_state("noisy81");
        send_bit(1'b1, -1);

        // Randomized frames
        for (int i = 0; i < 16; i++) begin
            b = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            noisy = ($urandom_range(0, 1) == 1);
            send_frame(b, stop, noisy);
            model_frame(b, stop);
            check_state($sformatf("rand%0d", i));
            if (!stop) begin
                send_bit(1'b1, -1);
                send_bit(1'b1, -1);
            end else if ($urandom_range(0, 1) == 1) begin
                send_bit(1'b1, -1);
            end
        end
        send_bit(1'b1, -1);
        #1;
        chk("final_idle", rx_busy, 1'b0);
        chk("never_both_pulses", both_high, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
